draw_pair_sequencer: RTL

- Sequences the even/odd address-pair generator that feeds the dual-port draw memory.
- Two requesters (0 = clear engine, 1 = draw engine) each ask for a run of N consecutive pair indices starting at a base.
- The block arbitrates round-robin, then streams addr_a = {idx,0} and addr_b = {idx,1} one pair per accepted beat under valid/ready.
- It pulses done to the owner when the run completes.

---
 rtl/draw_pkg.sv | 14 +
 rtl/rr_arb2.sv | 23 ++
 rtl/draw_pair_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared constants and state encoding for the draw-memory address-pair sequencer.
package draw_pkg;

  localparam int ADDR_W = 14;
  localparam int PAIR_W = ADDR_W - 1;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  // Grant selection; nothing is granted while disabled.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/draw_pair_sequencer.sv
// Even/odd address-pair sequencer for the dual-port draw memory.
// Arbitrates the clear engine (0) and draw engine (1), then streams
// {idx,0}/{idx,1} pairs under valid/ready and pulses done to the owner.
// Optional build macro DRAW_SEQ_STALL_CNT_EN adds the stall_cnt output.
module draw_pair_sequencer #(
  parameter int ADDR_W = draw_pkg::ADDR_W,
  parameter int LEN_W  = draw_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-2:0] req_base0,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [ADDR_W-2:0] req_base1,
  input  logic [LEN_W-1:0]  req_len1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
`ifdef DRAW_SEQ_STALL_CNT_EN
  output logic [ADDR_W-1:0] addr_b,
  output logic [15:0]       stall_cnt
`else
  output logic [ADDR_W-1:0] addr_b
`endif
);

  import draw_pkg::*;

  localparam int PW = ADDR_W - 1;

  seq_state_t        state, state_nxt;
  logic [PW-1:0]     idx, idx_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic              owner, owner_nxt;
  logic              last_g, last_g_nxt;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              beat;

  // Requests are only looked at in IDLE, and never while reset is held.
  assign arb_en = (state == IDLE) && !reset;

  rr_arb2 u_arb (
    .req      (req),
    .last_gnt (last_g),
    .en       (arb_en),
    .gnt      (arb_gnt)
  );

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign beat      = out_valid && out_ready;
  assign addr_a    = {idx, 1'b0};
  assign addr_b    = {idx, 1'b1};

  // Next-state, run bookkeeping and the one-cycle gnt/done pulses.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    rem_nxt    = rem;
    owner_nxt  = owner;
    last_g_nxt = last_g;
    gnt        = 2'b00;
    done       = 2'b00;
    case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt       = arb_gnt;
          owner_nxt = arb_gnt[1];
          idx_nxt   = arb_gnt[1] ? req_base1 : req_base0;
          rem_nxt   = arb_gnt[1] ? req_len1 : req_len0;
          // A zero-length run skips streaming and completes immediately.
          state_nxt = ((arb_gnt[1] ? req_len1 : req_len0) != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (beat) begin
          idx_nxt = idx + PW'(1);
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nxt = FIN;
        end
      end
      FIN: begin
        done       = owner ? 2'b10 : 2'b01;
        last_g_nxt = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and run registers; last_g resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      rem    <= '0;
      owner  <= 1'b0;
      last_g <= 1'b1;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      rem    <= rem_nxt;
      owner  <= owner_nxt;
      last_g <= last_g_nxt;
    end
  end

`ifdef DRAW_SEQ_STALL_CNT_EN
  // Saturating count of stalled RUN cycles; cleared on a new grant, held otherwise.
  always_ff @(posedge clk) begin
    if (reset || (gnt != 2'b00)) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
